// File: rtl/dyn_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dyn_adder_pkg
// Brief    : Shared types and helpers for the sequential dynamic adder.
// Revision : 1.0
// ============================================================================
package dyn_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STAT_W = 32;

    function automatic int nseg(input int width, input int seg);
        return width / seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dyn_adder_seg.sv
`default_nettype none
// ============================================================================
// Module   : dyn_adder_seg
// Brief    : SEG-bit combinational ripple slice of the dynamic adder.
// Revision : 1.0
// ============================================================================
module dyn_adder_seg
    import dyn_adder_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/dyn_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : dyn_adder_seq
// Brief    : Segmented adder with registered inter-segment carries and
//            settle detection; optional counters via DYN_ADDER_STATS_EN.
// Revision : 1.0
// ============================================================================
module dyn_adder_seq
    import dyn_adder_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int SEG   = 8,
    localparam int NSEG  = nseg(WIDTH, SEG),
    localparam int CW    = $clog2(NSEG + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    input  logic              req_cin,
    input  logic              req_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_sum,
    output logic              rsp_cout,
    output logic [CW-1:0]     rsp_cycles,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_cycles
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [NSEG:0]    r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [CW-1:0]    r_cycles;

    logic [WIDTH-1:0] w_sum;
    logic [NSEG-1:0]  w_cout;
    logic [NSEG:0]    w_c_next;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_settled;

    generate
        for (genvar i = 0; i < NSEG; i++) begin : g_seg
            dyn_adder_seg #(
                .SEG (SEG)
            ) u_seg (
                .a    (r_a[i*SEG +: SEG]),
                .b    (r_b[i*SEG +: SEG]),
                .cin  (r_c[i]),
                .sum  (w_sum[i*SEG +: SEG]),
                .cout (w_cout[i])
            );
        end
    endgenerate

    // Bit 0 is the operation carry-in and never changes during EVAL.
    assign w_c_next  = {w_cout, r_c[0]};
    assign w_settled = (w_c_next == r_c);
    assign w_cnt_inc = r_cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_next = EVAL;
            EVAL:    if (w_settled) w_state_next = DONE;
            DONE:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_cycles <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a   <= req_a;
                        r_b   <= req_sub ? ~req_b : req_b;
                        r_c   <= {{NSEG{1'b0}}, (req_sub | req_cin)};
                        r_cnt <= '0;
                    end
                end
                EVAL: begin
                    r_cnt <= w_cnt_inc;
                    if (w_settled) begin
                        r_sum    <= w_sum;
                        r_cout   <= r_c[NSEG];
                        r_cycles <= w_cnt_inc;
                    end else begin
                        r_c <= w_c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == DONE);
    assign rsp_sum    = r_sum;
    assign rsp_cout   = r_cout;
    assign rsp_cycles = r_cycles;

`ifdef DYN_ADDER_STATS_EN
    logic [STAT_W-1:0] r_stat_ops;
    logic [STAT_W-1:0] r_stat_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ops    <= '0;
            r_stat_cycles <= '0;
        end else if (rsp_valid && rsp_ready) begin
            r_stat_ops    <= r_stat_ops + STAT_W'(1);
            r_stat_cycles <= r_stat_cycles + STAT_W'(r_cycles);
        end
    end

    assign stat_ops    = r_stat_ops;
    assign stat_cycles = r_stat_cycles;
`else
    assign stat_ops    = '0;
    assign stat_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dyn_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dyn_adder_seq
// Brief    : Directed self-checking bench for dyn_adder_seq (WIDTH=32, SEG=8).
// Revision : 1.0
// ============================================================================
module tb_dyn_adder_seq;

    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int CW    = $clog2(WIDTH / SEG + 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_a;
    logic [WIDTH-1:0]  req_b;
    logic              req_cin;
    logic              req_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_sum;
    logic              rsp_cout;
    logic [CW-1:0]     rsp_cycles;
    logic [31:0]       stat_ops;
    logic [31:0]       stat_cycles;

    int tests = 0;
    int fails = 0;

    dyn_adder_seq #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_cin     (req_cin),
        .req_sub     (req_sub),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_sum     (rsp_sum),
        .rsp_cout    (rsp_cout),
        .rsp_cycles  (rsp_cycles),
        .stat_ops    (stat_ops),
        .stat_cycles (stat_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for rsp_valid after an accepting edge; returns cycles taken (20 = timeout).
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_rsp(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_ready_back"}, 64'(req_ready), 64'(1));
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] es,
                          input logic ec, input int ecyc);
        int n;
        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_sub   = sub;
        req_valid = 1'b1;
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(n);
        chk({tag, "_latency"}, 64'(n), 64'(ecyc));
        chk({tag, "_sum"}, 64'(rsp_sum), 64'(es));
        chk({tag, "_cout"}, 64'(rsp_cout), 64'(ec));
        chk({tag, "_cycles"}, 64'(rsp_cycles), 64'(ecyc));
        release_rsp(tag);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        req_sub   = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_sum", 64'(rsp_sum), 64'(0));
        chk("rst_cycles", 64'(rsp_cycles), 64'(0));
        chk("rst_stat_ops", 64'(stat_ops), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op("zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1);
        run_op("full", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 5);
        run_op("part", 32'h00FF_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h00FF_0100, 1'b0, 2);

`ifdef DYN_ADDER_STATS_EN
        chk("stat_ops", 64'(stat_ops), 64'(3));
        chk("stat_cycles", 64'(stat_cycles), 64'(8));
`else
        chk("stat_ops_off", 64'(stat_ops), 64'(0));
        chk("stat_cycles_off", 64'(stat_cycles), 64'(0));
`endif

        run_op("sub", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFE, 1'b1, 2);
        run_op("cin", 32'h0000_00FE, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 2);

        // Backpressure with a competing request held valid throughout.
        @(negedge clk);
        req_a     = 32'h00FF_00FF;
        req_b     = 32'h0000_0001;
        req_cin   = 1'b0;
        req_sub   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_a = 32'h1234_5678;
        req_b = 32'h1111_1111;
        chk("bp_busy_ready", 64'(req_ready), 64'(0));
        wait_rsp(n);
        chk("bp_latency", 64'(n), 64'(2));
        chk("bp_sum", 64'(rsp_sum), 64'(32'h00FF_0100));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(rsp_valid), 64'(1));
            chk("bp_hold_sum", 64'(rsp_sum), 64'(32'h00FF_0100));
            chk("bp_hold_cycles", 64'(rsp_cycles), 64'(2));
            chk("bp_hold_ready", 64'(req_ready), 64'(0));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_idle_ready", 64'(req_ready), 64'(1));
        chk("bp_idle_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp2_accepted", 64'(req_ready), 64'(0));
        wait_rsp(n);
        chk("bp2_latency", 64'(n), 64'(1));
        chk("bp2_sum", 64'(rsp_sum), 64'(32'h2345_6789));
        chk("bp2_cout", 64'(rsp_cout), 64'(0));
        release_rsp("bp2");

        // Reset two cycles into a long evaluation.
        @(negedge clk);
        req_a     = 32'hFFFF_FFFF;
        req_b     = 32'h0000_0001;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'(1));
        chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_sum", 64'(rsp_sum), 64'(0));
        chk("mid_rst_cycles", 64'(rsp_cycles), 64'(0));
        chk("mid_rst_stat_ops", 64'(stat_ops), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) n++;
        end
        chk("mid_rst_no_valid", 64'(n), 64'(0));
        chk("mid_rst_idle", 64'(req_ready), 64'(1));

        run_op("post_rst", 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 32'h0303_0303, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dyn_adder_seq.md
Name: dyn_adder_seq

Overview:
- Clocked, parametrised successor to the combinational dynamic adder.
- Operands are split into SEG-bit ripple segments. Carries between segments are registered and advance one segment per clock.
- Completion is detected when the inter-segment carry vector stops changing, so latency tracks the actual carry-chain length rather than the worst case.
- Sits between an operand producer and a result consumer using valid/ready handshakes, and adds a subtract mode.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, segment width in bits; NSEG = WIDTH/SEG, NSEG >= 1.
- CW, $clog2(NSEG+2), width of the rsp_cycles field (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  operands presented.
- req_ready  out  1  block can accept operands.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_cin  in  1  carry-in; ignored when req_sub=1.
- req_sub  in  1  1: compute A-B (A + ~B + 1).
- rsp_valid  out  1  result held valid.
- rsp_ready  in  1  consumer takes result.
- rsp_sum  out  WIDTH  result.
- rsp_cout  out  1  carry-out of top segment (for subtract: 1 = no borrow).
- rsp_cycles  out  CW  number of EVAL cycles used (N_eval).
- stat_ops  out  32  completed operations (optional feature).
- stat_cycles  out  32  cumulative EVAL cycles (optional feature).

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=1; rsp_valid=0; rsp_sum=0; rsp_cout=0; rsp_cycles=0; carry register=0; stats=0. Reset mid-EVAL discards the operation with no output.
- States: IDLE -> EVAL -> DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch A, B_eff = sub ? ~B : B, and cin_eff = sub ? 1 : cin.
  - Load carry vector c[NSEG:0] with c[0]=cin_eff and all others 0.
  - Go to EVAL with eval counter = 0.
- EVAL (req_ready=0), each cycle:
  - Segment i computes sum_i and cout_i from latched A/B_eff slice and c[i].
  - next c[i+1] = cout_i for i = 0..NSEG-1; c[0] is held.
  - Increment the counter.
  - If next c == c: register rsp_sum = concatenated sums, rsp_cout = c[NSEG], rsp_cycles = counter+1; go to DONE.
  - Otherwise update c and stay in EVAL.
- DONE: rsp_valid=1; all rsp_* outputs stable while rsp_ready=0. On rsp_ready go to IDLE. req_ready stays 0 during DONE (no overlap).
- Latency: rsp_valid rises exactly N_eval cycles after the accepting edge.
  - N_eval min = 1 (no inter-segment carry).
  - N_eval max = NSEG+1 (carry rippling the full chain).
- Result always equals (A + B_eff + cin_eff) mod 2^(WIDTH+1), split into {rsp_cout, rsp_sum}.
- req_valid while not ready: no effect, and inputs are not sampled.
- NSEG=1: always N_eval=1.

Optional Feature:
- Macro DYN_ADDER_STATS_EN.
- Defined:
  - stat_ops increments by 1 on each rsp_valid&&rsp_ready.
  - stat_cycles adds rsp_cycles on the same event.
  - Both wrap mod 2^32 and are cleared by rst.
- Undefined: stat_ops and stat_cycles are tied to 0 and no counter logic is generated.

Decomposition:
- Package dyn_adder_pkg:
  - state enum type (IDLE, EVAL, DONE).
  - function nseg(width, seg).
  - localparam for the stat counter width (32).
- Sub-module dyn_adder_seg: SEG-bit combinational ripple slice (a, b, cin -> sum, cout); instantiated NSEG times by generate.
- Top holds the FSM, operand/carry registers, handshake and stats.

Test Plan (WIDTH=32, SEG=8):
- A=0, B=0, cin=0, add -> rsp_sum=0x00000000, cout=0, rsp_cycles=1; rsp_valid 1 cycle after accept.
- A=0xFFFFFFFF, B=0x00000001, add -> rsp_sum=0, cout=1, rsp_cycles=5; rsp_valid 5 cycles after accept.
- A=0x00FF00FF, B=0x00000001, add -> rsp_sum=0x00FF0100, cout=0, rsp_cycles=2.
- A=0x7FFFFFFF, B=0x00000001, sub, cin=0 (ignored) -> rsp_sum=0x7FFFFFFE, cout=1, rsp_cycles=2.
- Backpressure and busy handling:
  - Hold rsp_ready=0 for 4 cycles after rsp_valid -> outputs stable, req_ready=0.
  - Drive req_valid with new operands during EVAL/DONE -> ignored; accepted only once back in IDLE.
- Reset and stats:
  - Assert rst 2 cycles into the FFFFFFFF+1 EVAL -> immediate IDLE, rsp_valid never asserted, req_ready=1.
  - With DYN_ADDER_STATS_EN, after cases 1-3: stat_ops=3, stat_cycles=8.
